fetch_queue: RTL and testbench

- Fetch-stage front end that owns the fetch PC and drives the instruction ROM address.
- Captures each returned instruction word, with its PC, into a small in-order FIFO.
- Presents the FIFO head to decode over a valid/ready handshake.
- Decouples decode stalls from fetch and flushes on branch/jump redirects from execute.

---
 rtl/fetch_queue_if.sv | 46 ++++
 rtl/fetch_queue.sv | 84 ++++++++
 tb/tb_fetch_queue.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// Fetch-queue signal bundle: instruction ROM address/data, execute redirect,
// and the decode-facing head-of-queue valid/ready channel.
interface fetch_queue_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int INSTR_WIDTH   = 32,
  parameter int DEPTH         = 4
);
  logic [ADDRESS_WIDTH-1:0]   imem_addr;
  logic [INSTR_WIDTH-1:0]     imem_instr;
  logic                       redirect;
  logic [ADDRESS_WIDTH-1:0]   redirect_pc;
  logic                       out_valid;
  logic                       out_ready;
  logic [INSTR_WIDTH-1:0]     out_instr;
  logic [ADDRESS_WIDTH-1:0]   out_pc;
  logic [ADDRESS_WIDTH-1:0]   out_pc_plus4;
  logic [$clog2(DEPTH):0]     count;

  // Fetch queue side.
  modport master (
    output imem_addr,
    input  imem_instr,
    input  redirect,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc,
    output out_pc_plus4,
    output count
  );

  // ROM / execute / decode side.
  modport slave (
    input  imem_addr,
    output imem_instr,
    output redirect,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc,
    input  out_pc_plus4,
    input  count
  );
endinterface

// File: rtl/fetch_queue.sv
// Fetch front end: owns the fetch PC, captures ROM words with their PC into an
// in-order FIFO, and presents the head to decode; redirects flush and restart.
module fetch_queue #(
  parameter int                    ADDRESS_WIDTH = 32,
  parameter int                    INSTR_WIDTH   = 32,
  parameter int                    DEPTH         = 4,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic           clk,
  input  logic           rst,
  fetch_queue_if.master  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [INSTR_WIDTH-1:0] NOP = INSTR_WIDTH'(32'h0000_0013);

  // Handshake: an entry transfers to decode on a cycle where out_valid and
  // out_ready are both high at the rising edge; out_valid never depends on
  // out_ready, and out_ready is ignored while the queue is empty.

  logic [ADDRESS_WIDTH-1:0] fetch_pc;
  logic [INSTR_WIDTH-1:0]   instr_mem [DEPTH];
  logic [ADDRESS_WIDTH-1:0] pc_mem    [DEPTH];
  logic [PTR_W-1:0]         rd_ptr;
  logic [PTR_W-1:0]         wr_ptr;
  logic [CNT_W-1:0]         count;

  logic empty;
  logic full;
  logic pop;
  logic push;

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);
  assign pop   = !empty && bus.out_ready;
  // A full queue still accepts a word when the head leaves in the same cycle.
  assign push  = !bus.redirect && (!full || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (bus.redirect) begin
      fetch_pc <= {bus.redirect_pc[ADDRESS_WIDTH-1:2], 2'b00};
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        fetch_pc <= fetch_pc + ADDRESS_WIDTH'(4);
        wr_ptr   <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is data-only; validity is tracked entirely by count.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      instr_mem[wr_ptr] <= bus.imem_instr;
      pc_mem[wr_ptr]    <= fetch_pc;
    end
  end

  logic [ADDRESS_WIDTH-1:0] head_pc;
  assign head_pc = empty ? '0 : pc_mem[rd_ptr];

  assign bus.imem_addr    = fetch_pc;
  assign bus.out_valid    = !empty;
  assign bus.out_instr    = empty ? NOP : instr_mem[rd_ptr];
  assign bus.out_pc       = head_pc;
  assign bus.out_pc_plus4 = head_pc + ADDRESS_WIDTH'(4);
  assign bus.count        = count;
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: ROM returns its own byte address as the word,
// so every expected instruction equals its expected PC.
module tb_fetch_queue;
  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  fetch_queue_if #(.ADDRESS_WIDTH(32), .INSTR_WIDTH(32), .DEPTH(4)) bus ();

  fetch_queue #(
    .ADDRESS_WIDTH(32), .INSTR_WIDTH(32), .DEPTH(4), .RESET_PC(32'h0000_0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.imem_instr = bus.imem_addr;

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.redirect = 1'b0;
    bus.redirect_pc = '0;
    bus.out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.redirect = 1'b0;
    bus.redirect_pc = '0;
    bus.out_ready = 1'b1;
    step();
    step();
    tests_run++;
    if (bus.out_valid !== 1'b0) begin
      $display("FAIL reset_valid got %0b exp 0", bus.out_valid); tests_failed++;
    end
    tests_run++;
    if (bus.count !== 3'd0) begin
      $display("FAIL reset_count got %0d exp 0", bus.count); tests_failed++;
    end
    tests_run++;
    if (bus.out_instr !== 32'h13) begin
      $display("FAIL reset_instr got %h exp 00000013", bus.out_instr); tests_failed++;
    end
    tests_run++;
    if (bus.out_pc !== 32'h0 || bus.out_pc_plus4 !== 32'h4) begin
      $display("FAIL reset_pc got %h/%h exp 00000000/00000004", bus.out_pc, bus.out_pc_plus4);
      tests_failed++;
    end
    tests_run++;
    if (bus.imem_addr !== 32'h0) begin
      $display("FAIL reset_addr got %h exp 00000000", bus.imem_addr); tests_failed++;
    end
  endtask

  task automatic test_stream();
    do_reset();
    bus.out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      tests_run++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'(4 * k) ||
          bus.out_instr !== 32'(4 * k) || bus.count !== 3'd1) begin
        $display("FAIL stream_%0d got v=%0b pc=%h instr=%h cnt=%0d exp v=1 pc=%h instr=%h cnt=1",
                 k, bus.out_valid, bus.out_pc, bus.out_instr, bus.count, 32'(4 * k), 32'(4 * k));
        tests_failed++;
      end
    end
  endtask

  task automatic test_fill_full_pop();
    do_reset();
    bus.out_ready = 1'b0;
    for (int k = 0; k < 6; k++) step();
    tests_run++;
    if (bus.count !== 3'd4 || bus.imem_addr !== 32'h10 || bus.out_pc !== 32'h0) begin
      $display("FAIL fill_stall got cnt=%0d addr=%h pc=%h exp cnt=4 addr=00000010 pc=00000000",
               bus.count, bus.imem_addr, bus.out_pc);
      tests_failed++;
    end
    // One pop while full: push still happens and count holds.
    bus.out_ready = 1'b1;
    step();
    tests_run++;
    if (bus.count !== 3'd4 || bus.imem_addr !== 32'h14 || bus.out_pc !== 32'h4) begin
      $display("FAIL full_pop got cnt=%0d addr=%h pc=%h exp cnt=4 addr=00000014 pc=00000004",
               bus.count, bus.imem_addr, bus.out_pc);
      tests_failed++;
    end
    for (int k = 0; k < 5; k++) begin
      step();
      tests_run++;
      if (bus.out_pc !== 32'(8 + 4 * k) || bus.out_instr !== 32'(8 + 4 * k) ||
          bus.count !== 3'd4) begin
        $display("FAIL drain_%0d got pc=%h instr=%h cnt=%0d exp pc=%h cnt=4",
                 k, bus.out_pc, bus.out_instr, bus.count, 32'(8 + 4 * k));
        tests_failed++;
      end
    end
  endtask

  task automatic test_redirect();
    do_reset();
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) step();
    tests_run++;
    if (bus.count !== 3'd3) begin
      $display("FAIL redir_pre_count got %0d exp 3", bus.count); tests_failed++;
    end
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h43;
    step();
    bus.redirect = 1'b0;
    tests_run++;
    if (bus.count !== 3'd0 || bus.out_valid !== 1'b0 || bus.out_instr !== 32'h13 ||
        bus.imem_addr !== 32'h40) begin
      $display("FAIL redir_flush got cnt=%0d v=%0b instr=%h addr=%h exp cnt=0 v=0 instr=00000013 addr=00000040",
               bus.count, bus.out_valid, bus.out_instr, bus.imem_addr);
      tests_failed++;
    end
    step();
    tests_run++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h40 || bus.out_pc_plus4 !== 32'h44 ||
        bus.out_instr !== 32'h40) begin
      $display("FAIL redir_first got v=%0b pc=%h pc4=%h instr=%h exp v=1 pc=00000040 pc4=00000044 instr=00000040",
               bus.out_valid, bus.out_pc, bus.out_pc_plus4, bus.out_instr);
      tests_failed++;
    end
  endtask

  task automatic test_redirect_full_pop();
    do_reset();
    bus.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) step();
    bus.out_ready = 1'b1;
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h200;
    step();
    bus.redirect = 1'b0;
    tests_run++;
    if (bus.count !== 3'd0 || bus.out_valid !== 1'b0 || bus.imem_addr !== 32'h200) begin
      $display("FAIL redir_full got cnt=%0d v=%0b addr=%h exp cnt=0 v=0 addr=00000200",
               bus.count, bus.out_valid, bus.imem_addr);
      tests_failed++;
    end
    step();
    step();
    tests_run++;
    if (bus.out_pc !== 32'h204 || bus.count !== 3'd1) begin
      $display("FAIL redir_full_stream got pc=%h cnt=%0d exp pc=00000204 cnt=1",
               bus.out_pc, bus.count);
      tests_failed++;
    end
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b1;
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h100;
    step();
    bus.redirect_pc = 32'h302;
    step();
    bus.redirect = 1'b0;
    tests_run++;
    if (bus.imem_addr !== 32'h300 || bus.count !== 3'd0) begin
      $display("FAIL b2b_redir got addr=%h cnt=%0d exp addr=00000300 cnt=0",
               bus.imem_addr, bus.count);
      tests_failed++;
    end
    step();
    tests_run++;
    if (bus.out_pc !== 32'h300 || bus.out_valid !== 1'b1) begin
      $display("FAIL b2b_first got pc=%h v=%0b exp pc=00000300 v=1", bus.out_pc, bus.out_valid);
      tests_failed++;
    end
  endtask

  task automatic test_reset_with_redirect();
    bus.out_ready = 1'b0;
    step();
    step();
    rst = 1'b1;
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h500;
    step();
    rst = 1'b0;
    bus.redirect = 1'b0;
    tests_run++;
    if (bus.imem_addr !== 32'h0 || bus.count !== 3'd0 || bus.out_valid !== 1'b0) begin
      $display("FAIL rst_redir got addr=%h cnt=%0d v=%0b exp addr=00000000 cnt=0 v=0",
               bus.imem_addr, bus.count, bus.out_valid);
      tests_failed++;
    end
    step();
    tests_run++;
    if (bus.out_pc !== 32'h0 || bus.out_valid !== 1'b1 || bus.count !== 3'd1) begin
      $display("FAIL rst_redir_first got pc=%h v=%0b cnt=%0d exp pc=00000000 v=1 cnt=1",
               bus.out_pc, bus.out_valid, bus.count);
      tests_failed++;
    end
  endtask

  task automatic test_pc_wrap();
    bus.out_ready = 1'b1;
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFC;
    step();
    bus.redirect = 1'b0;
    tests_run++;
    if (bus.imem_addr !== 32'hFFFF_FFFC) begin
      $display("FAIL wrap_addr got %h exp fffffffc", bus.imem_addr); tests_failed++;
    end
    step();
    tests_run++;
    if (bus.out_pc !== 32'hFFFF_FFFC || bus.out_pc_plus4 !== 32'h0 ||
        bus.out_instr !== 32'hFFFF_FFFC) begin
      $display("FAIL wrap_first got pc=%h pc4=%h instr=%h exp pc=fffffffc pc4=00000000 instr=fffffffc",
               bus.out_pc, bus.out_pc_plus4, bus.out_instr);
      tests_failed++;
    end
    step();
    tests_run++;
    if (bus.out_pc !== 32'h0 || bus.out_pc_plus4 !== 32'h4 || bus.imem_addr !== 32'h4) begin
      $display("FAIL wrap_second got pc=%h pc4=%h addr=%h exp pc=00000000 pc4=00000004 addr=00000004",
               bus.out_pc, bus.out_pc_plus4, bus.imem_addr);
      tests_failed++;
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst = 1'b1;
    bus.redirect = 1'b0;
    bus.redirect_pc = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_stream();
    test_fill_full_pop();
    test_redirect();
    test_redirect_full_pop();
    test_back_to_back();
    test_reset_with_redirect();
    test_pc_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
